// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for a simple bus-based datapath.
// Walks each instruction through T0..T5. Outputs are decoded from the
// current state, and from the opcode field IR[31:27] in T3/T4.
// Optional feature macro: SEQ_MEMWAIT_EN. When it is defined, T1 holds until
// Mem_ready is seen high at a rising edge. When it is undefined, T1 lasts one
// cycle and Mem_ready is ignored.
module control_sequencer (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Stop,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        Run
);

  typedef enum logic [2:0] {
    RST  = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5,
    T5   = 3'd6,
    HALT = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state;
  state_t     state_next;
  state_t     boundary_next;
  logic [4:0] opcode;
  logic       is_alu;
  logic       is_halt;

  // Only the opcode field is used here; the register fields go to the datapath.
`ifdef SEQ_MEMWAIT_EN
  logic unused_ir;
  assign unused_ir = ^IR[26:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{Mem_ready, IR[26:0]};
`endif

  assign opcode  = IR[31:27];
  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_halt = (opcode == OP_HALT);

  // Register the state. Reset wins over every other input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= RST;
    end else begin
      state <= state_next;
    end
  end

  // Choose the next state. Stop is sampled only at an instruction boundary.
  always_comb begin
    boundary_next = Stop ? HALT : T0;
    state_next    = state;
    unique case (state)
      RST:  state_next = T0;
      T0:   state_next = T1;
`ifdef SEQ_MEMWAIT_EN
      T1:   state_next = Mem_ready ? T2 : T1;
`else
      T1:   state_next = T2;
`endif
      T2:   state_next = T3;
      T3: begin
        if (is_alu) begin
          state_next = T4;
        end else if (is_halt) begin
          state_next = HALT;
        end else begin
          state_next = boundary_next;
        end
      end
      T4:   state_next = T5;
      T5:   state_next = boundary_next;
      HALT: state_next = HALT;
      default: state_next = RST;
    endcase
  end

  // Decode the outputs from the current state, and from the opcode in T3/T4.
  always_comb begin
    PCout   = 1'b0;
    Zlowout = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    Zin     = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    ADD     = 1'b0;
    SUB     = 1'b0;
    AND     = 1'b0;
    OR      = 1'b0;
    Run     = 1'b0;
    unique case (state)
      T0: begin
        Run   = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        Run    = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        Run = 1'b1;
        if (is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      T4: begin
        Run  = 1'b1;
        Grc  = 1'b1;
        Rout = 1'b1;
        Zin  = 1'b1;
        ADD  = (opcode == OP_ADD);
        SUB  = (opcode == OP_SUB);
        AND  = (opcode == OP_AND);
        OR   = (opcode == OP_OR);
      end
      T5: begin
        Run     = 1'b1;
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
      end
      default: begin
        Run = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. All outputs are packed into one vector
// and compared with hand-built expected vectors once each cycle, after the edge.
module tb_control_sequencer;

  logic        Clock;
  logic        Reset;
  logic [31:0] IR;
  logic        Stop;
  logic        Mem_ready;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, Run;

  int unsigned tests;
  int unsigned fails;

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Stop(Stop), .Mem_ready(Mem_ready),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
  );

  localparam logic [20:0] O_PCOUT   = 21'd1 << 20;
  localparam logic [20:0] O_ZLOWOUT = 21'd1 << 19;
  localparam logic [20:0] O_MDROUT  = 21'd1 << 18;
  localparam logic [20:0] O_MARIN   = 21'd1 << 17;
  localparam logic [20:0] O_ZIN     = 21'd1 << 16;
  localparam logic [20:0] O_PCIN    = 21'd1 << 15;
  localparam logic [20:0] O_MDRIN   = 21'd1 << 14;
  localparam logic [20:0] O_IRIN    = 21'd1 << 13;
  localparam logic [20:0] O_YIN     = 21'd1 << 12;
  localparam logic [20:0] O_INCPC   = 21'd1 << 11;
  localparam logic [20:0] O_READ    = 21'd1 << 10;
  localparam logic [20:0] O_GRA     = 21'd1 << 9;
  localparam logic [20:0] O_GRB     = 21'd1 << 8;
  localparam logic [20:0] O_GRC     = 21'd1 << 7;
  localparam logic [20:0] O_RIN     = 21'd1 << 6;
  localparam logic [20:0] O_ROUT    = 21'd1 << 5;
  localparam logic [20:0] O_ADD     = 21'd1 << 4;
  localparam logic [20:0] O_SUB     = 21'd1 << 3;
  localparam logic [20:0] O_AND     = 21'd1 << 2;
  localparam logic [20:0] O_OR      = 21'd1 << 1;
  localparam logic [20:0] O_RUN     = 21'd1;

  localparam logic [20:0] E_IDLE = '0;
  localparam logic [20:0] E_T0   = O_PCOUT | O_MARIN | O_INCPC | O_ZIN | O_RUN;
  localparam logic [20:0] E_T1   = O_ZLOWOUT | O_PCIN | O_READ | O_MDRIN | O_RUN;
  localparam logic [20:0] E_T2   = O_MDROUT | O_IRIN | O_RUN;
  localparam logic [20:0] E_T3A  = O_GRB | O_ROUT | O_YIN | O_RUN;
  localparam logic [20:0] E_T3N  = O_RUN;
  localparam logic [20:0] E_T4   = O_GRC | O_ROUT | O_ZIN | O_RUN;
  localparam logic [20:0] E_T5   = O_ZLOWOUT | O_GRA | O_RIN | O_RUN;

  logic [20:0] obs;
  assign obs = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC,
                Read, Gra, Grb, Grc, Rin, Rout, ADD, SUB, AND, OR, Run};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [20:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1;
    Stop = 1'b0;
    Mem_ready = 1'b0;
    IR = 32'h0;

    // Reset held for two edges, then a single RST cycle, then T0.
    step(); chk("rst_edge1", E_IDLE);
    step(); chk("rst_edge2", E_IDLE);
    Reset = 1'b0;
    chk("rst_first_cycle", E_IDLE);
    step(); chk("t0_after_rst", E_T0);

    // AND instruction, R1 R2 R3.
    IR = 32'h28918000;
    step(); chk("and_t1", E_T1);
    step(); chk("and_t2", E_T2);
    step(); chk("and_t3", E_T3A);
    step(); chk("and_t4", E_T4 | O_AND);
    step(); chk("and_t5", E_T5);
    step(); chk("and_next_t0", E_T0);

    // NOP: four cycles, no outputs besides Run in T3.
    IR = 32'hD0000000;
    step(); chk("nop_t1", E_T1);
    step(); chk("nop_t2", E_T2);
    step(); chk("nop_t3", E_T3N);
    step(); chk("nop_next_t0", E_T0);

    // Undefined opcode behaves as NOP.
    IR = 32'hF8000000;
    step(); chk("undef_t1", E_T1);
    step(); chk("undef_t2", E_T2);
    step(); chk("undef_t3", E_T3N);
    step(); chk("undef_next_t0", E_T0);

    // ADD with IR changing during T4: ALU select follows in the same cycle.
    // Stop raised mid-instruction is ignored; at the T5 boundary it halts.
    IR = 32'h18918000;
    Stop = 1'b1;
    step(); chk("stop_ignored_t1", E_T1);
    step(); chk("add_t2", E_T2);
    step(); chk("add_t3", E_T3A);
    step(); chk("add_t4", E_T4 | O_ADD);
    IR = 32'h20000000;
    #1 chk("t4_follow_sub", E_T4 | O_SUB);
    IR = 32'h30000000;
    #1 chk("t4_follow_or", E_T4 | O_OR);
    step(); chk("or_t5", E_T5);
    step(); chk("stop_halt", E_IDLE);
    Stop = 1'b0;
    step(); chk("stop_halt_hold", E_IDLE);
    Reset = 1'b1;
    step(); chk("halt_reset_rst", E_IDLE);
    Reset = 1'b0;
    step(); chk("halt_reset_t0", E_T0);

    // Reset during T4 of an ADD: next edge is RST, T5 never occurs.
    IR = 32'h18918000;
    step(); chk("add2_t1", E_T1);
    step(); chk("add2_t2", E_T2);
    step(); chk("add2_t3", E_T3A);
    step(); chk("add2_t4", E_T4 | O_ADD);
    Reset = 1'b1;
    Stop = 1'b1;
    step(); chk("midinst_reset_rst", E_IDLE);
    Reset = 1'b0;
    Stop = 1'b0;
    step(); chk("midinst_reset_t0", E_T0);

    // HALT opcode: T3 then HALT, stuck for 10 cycles regardless of Stop/IR.
    IR = 32'hD8000000;
    step(); chk("halt_t1", E_T1);
    step(); chk("halt_t2", E_T2);
    step(); chk("halt_t3", E_T3N);
    step(); chk("halt_enter", E_IDLE);
    for (int i = 0; i < 10; i++) begin
      Stop = 1'($urandom_range(0, 1));
      IR = $urandom;
      step(); chk("halt_stay", E_IDLE);
    end
    Stop = 1'b0;
    IR = 32'h18918000;
    Reset = 1'b1;
    step(); chk("halt_op_reset_rst", E_IDLE);
    Reset = 1'b0;
    step(); chk("halt_op_reset_t0", E_T0);

    // Memory wait in T1.
    Mem_ready = 1'b0;
    step(); chk("mem_t1_c1", E_T1);
`ifdef SEQ_MEMWAIT_EN
    step(); chk("mem_t1_c2", E_T1);
    step(); chk("mem_t1_c3", E_T1);
    step(); chk("mem_t1_c4", E_T1);
    Mem_ready = 1'b1;
    step(); chk("mem_t2", E_T2);
`else
    step(); chk("mem_ignored_t2", E_T2);
`endif
    Mem_ready = 1'b0;
    step(); chk("mem_t3", E_T3A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
